// File: rtl/mem_resp_pkg.sv
// Shared types, constants and the access error rule for the memory responder.
// Used by mem_responder and mem_array.
package mem_resp_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam int WORD_LSB = 2;
   localparam int ADDR_W   = 32;

   // An access fails when it is not word aligned or its word index falls past the array.
   function automatic logic is_err(input logic [ADDR_W-1:0] addr, input int unsigned depth);
      logic [ADDR_W-1:0] word_idx;
      word_idx = addr >> WORD_LSB;
      return (addr[WORD_LSB-1:0] != 2'b00) || (word_idx >= depth);
   endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous word RAM with registered, enable-gated read; contents
// are never reset so they survive a responder reset.
module mem_array #(
   parameter int DEPTH  = 256,
   parameter int DATA_W = 32
) (
   input  logic                     clk,
   input  logic                     en,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] addr,
   input  logic [DATA_W-1:0]        wdata,
   output logic [DATA_W-1:0]        rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   // Write port and read register; rdata only moves on an enabled read.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
      if (en) begin
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/mem_responder.sv
// Wait-state memory responder: one request at a time, WAIT_CYCLES extra cycles, one-cycle response.
// Optional access counters are built when MEM_RESP_STATS_EN is defined.
module mem_responder
   import mem_resp_pkg::*;
#(
   parameter int DEPTH       = 256,
   parameter int WAIT_CYCLES = 2,
   parameter int DATA_W      = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err
`ifdef MEM_RESP_STATS_EN
   ,
   output logic [31:0]       stat_reads,
   output logic [31:0]       stat_writes,
   output logic [31:0]       stat_errs
`endif
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

   generate
      if (DATA_W != 32) begin : g_bad_data_w
         $error("mem_responder: DATA_W must be 32");
      end
      if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
         $error("mem_responder: DEPTH must be a power of two and at least 4");
      end
      if ((WAIT_CYCLES < 0) || (WAIT_CYCLES > 15)) begin : g_bad_wait
         $error("mem_responder: WAIT_CYCLES must be in 0..15");
      end
   endgenerate

   state_t              state, state_next;
   logic [3:0]          cnt, cnt_next;
   logic                accept;
   logic                ready_r;
   logic                resp_valid_r;
   logic                resp_err_r;
   logic                rdata_zero_r;
   logic                lat_we;
   logic [ADDR_W-1:0]   lat_addr;
   logic [DATA_W-1:0]   lat_wdata;
   logic                cur_we;
   logic [ADDR_W-1:0]   cur_addr;
   logic [DATA_W-1:0]   cur_wdata;
   logic                cur_err;
   logic                enter_resp;
   logic                mem_we;
   logic                mem_en;
   logic [IDX_W-1:0]    mem_addr;
   logic [DATA_W-1:0]   mem_rdata;

   // Next-state and wait counter logic.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      accept     = 1'b0;
      case (state)
         IDLE: begin
            if (req_valid && ready_r) begin
               accept   = 1'b1;
               cnt_next = WAIT_LOAD;
               if (WAIT_CYCLES > 0) begin
                  state_next = WAIT;
               end else begin
                  state_next = RESP;
               end
            end else begin
               state_next = IDLE;
            end
         end
         WAIT: begin
            cnt_next = cnt - 4'd1;
            if (cnt == 4'd1) begin
               state_next = RESP;
            end else begin
               state_next = WAIT;
            end
         end
         RESP: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
            cnt_next   = 4'd0;
         end
      endcase
   end

   // With zero wait states RESP is entered on the acceptance edge itself, so the
   // live request must be used there instead of the not-yet-latched copy.
   always_comb begin
      if (state == IDLE) begin
         cur_we    = req_we;
         cur_addr  = req_addr;
         cur_wdata = req_wdata;
      end else begin
         cur_we    = lat_we;
         cur_addr  = lat_addr;
         cur_wdata = lat_wdata;
      end
   end

   // Array controls: commit or read only on the edge entering RESP, never under reset.
   always_comb begin
      cur_err    = is_err(cur_addr, DEPTH);
      enter_resp = (state_next == RESP);
      mem_we     = enter_resp && !reset && cur_we && !cur_err;
      mem_en     = enter_resp && !reset && !cur_we && !cur_err;
      mem_addr   = cur_addr[WORD_LSB +: IDX_W];
   end

   mem_array #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W)
   ) u_mem_array (
      .clk   (clk),
      .en    (mem_en),
      .we    (mem_we),
      .addr  (mem_addr),
      .wdata (cur_wdata),
      .rdata (mem_rdata)
   );

   // FSM state, request latch and registered handshake/response flags.
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         cnt          <= 4'd0;
         ready_r      <= 1'b0;
         resp_valid_r <= 1'b0;
         resp_err_r   <= 1'b0;
         rdata_zero_r <= 1'b1;
         lat_we       <= 1'b0;
         lat_addr     <= 32'd0;
         lat_wdata    <= 32'd0;
      end else begin
         state        <= state_next;
         cnt          <= cnt_next;
         ready_r      <= (state_next == IDLE);
         resp_valid_r <= enter_resp;
         if (accept) begin
            lat_we    <= req_we;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
         end else begin
            lat_we    <= lat_we;
            lat_addr  <= lat_addr;
            lat_wdata <= lat_wdata;
         end
         if (enter_resp) begin
            resp_err_r   <= cur_err;
            rdata_zero_r <= cur_err || cur_we;
         end else begin
            resp_err_r   <= 1'b0;
            rdata_zero_r <= rdata_zero_r;
         end
      end
   end

   // Read data comes straight from the array register; error and write responses force zero.
   assign resp_rdata = rdata_zero_r ? 32'd0 : mem_rdata;
   assign req_ready  = ready_r;
   assign resp_valid = resp_valid_r;
   assign resp_err   = resp_err_r;

`ifdef MEM_RESP_STATS_EN
   logic [31:0] reads_r, writes_r, errs_r;

   // Per-type access counters, bumped on the edge entering RESP; they wrap naturally.
   always_ff @(posedge clk) begin
      if (reset) begin
         reads_r  <= 32'd0;
         writes_r <= 32'd0;
         errs_r   <= 32'd0;
      end else if (enter_resp) begin
         if (cur_err) begin
            errs_r <= errs_r + 32'd1;
         end else if (cur_we) begin
            writes_r <= writes_r + 32'd1;
         end else begin
            reads_r <= reads_r + 32'd1;
         end
      end else begin
         reads_r  <= reads_r;
         writes_r <= writes_r;
         errs_r   <= errs_r;
      end
   end

   assign stat_reads  = reads_r;
   assign stat_writes = writes_r;
   assign stat_errs   = errs_r;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed scenarios plus random traffic against
// a word-indexed reference memory; one instance with 2 wait states, one with none.
module tb_mem_responder;

   localparam int DEPTH = 256;
   localparam int WA    = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        a_valid, a_ready, a_we, a_rvalid, a_err;
   logic [31:0] a_addr, a_wdata, a_rdata;
   logic        b_valid, b_ready, b_we, b_rvalid, b_err;
   logic [31:0] b_addr, b_wdata, b_rdata;

   int n_checks = 0;
   int n_fail   = 0;

   // reference memory: key = dut*4096 + word index
   logic [31:0] model [int unsigned];
   int          acc_q[$];
   int          rsp_q[$];
   logic [31:0] rd_q[$];

   always #5 clk = ~clk;

`ifdef MEM_RESP_STATS_EN
   logic [31:0] a_sr, a_sw, a_se, b_sr, b_sw, b_se;
`endif

   mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(WA), .DATA_W(32)) dut_a (
      .clk(clk), .reset(reset),
      .req_valid(a_valid), .req_ready(a_ready), .req_we(a_we),
      .req_addr(a_addr), .req_wdata(a_wdata),
      .resp_valid(a_rvalid), .resp_rdata(a_rdata), .resp_err(a_err)
`ifdef MEM_RESP_STATS_EN
      , .stat_reads(a_sr), .stat_writes(a_sw), .stat_errs(a_se)
`endif
   );

   mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0), .DATA_W(32)) dut_b (
      .clk(clk), .reset(reset),
      .req_valid(b_valid), .req_ready(b_ready), .req_we(b_we),
      .req_addr(b_addr), .req_wdata(b_wdata),
      .resp_valid(b_rvalid), .resp_rdata(b_rdata), .resp_err(b_err)
`ifdef MEM_RESP_STATS_EN
      , .stat_reads(b_sr), .stat_writes(b_sw), .stat_errs(b_se)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic drive(input bit sel, input logic v, input logic we,
                        input logic [31:0] ad, input logic [31:0] wd);
      if (sel) begin
         b_valid = v; b_we = we; b_addr = ad; b_wdata = wd;
      end else begin
         a_valid = v; a_we = we; a_addr = ad; a_wdata = wd;
      end
   endtask

   // One complete transaction on the selected DUT, checked against the model.
   task automatic txn(input bit sel, input logic we, input logic [31:0] ad,
                      input logic [31:0] wd, input string tag);
      int          waited;
      int          lat;
      bit          exp_err;
      int unsigned key;
      logic [31:0] got_rd;
      exp_err = ((ad % 32'd4) != 32'd0) || ((ad / 32'd4) >= 32'(DEPTH));
      key     = (sel ? 32'd4096 : 32'd0) + (ad / 32'd4);
      @(negedge clk);
      drive(sel, 1'b1, we, ad, wd);
      waited = 0;
      while ((sel ? b_ready : a_ready) !== 1'b1 && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      check({tag, " accept"}, {31'd0, (sel ? b_ready : a_ready)}, 32'd1);
      @(posedge clk);
      #1;
      drive(sel, 1'b0, 1'($urandom), $urandom, $urandom);
      lat = 0;
      @(negedge clk);
      while ((sel ? b_rvalid : a_rvalid) !== 1'b1 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check({tag, " latency"}, 32'(lat), sel ? 32'd0 : 32'(WA));
      check({tag, " err"}, {31'd0, (sel ? b_err : a_err)}, {31'd0, exp_err});
      got_rd = sel ? b_rdata : a_rdata;
      if (exp_err) begin
         check({tag, " err rdata"}, got_rd, 32'd0);
      end else if (!we && model.exists(key)) begin
         check({tag, " rdata"}, got_rd, model[key]);
      end
      if (!exp_err && we) model[key] = wd;
      @(negedge clk);
      check({tag, " pulse"}, {31'd0, (sel ? b_rvalid : a_rvalid)}, 32'd0);
      check({tag, " ready again"}, {31'd0, (sel ? b_ready : a_ready)}, 32'd1);
      if (!exp_err && !we && model.exists(key)) begin
         check({tag, " rdata hold"}, sel ? b_rdata : a_rdata, model[key]);
      end
   endtask

   initial begin
      int          r;
      logic [31:0] ad;
      reset = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
      repeat (3) @(negedge clk);
      check("rst ready", {31'd0, a_ready}, 32'd0);
      check("rst rvalid", {31'd0, a_rvalid}, 32'd0);
      reset = 1'b0;
      @(negedge clk);
      check("post-rst ready", {31'd0, a_ready}, 32'd1);
      check("post-rst rvalid", {31'd0, a_rvalid}, 32'd0);
      check("post-rst rdata", a_rdata, 32'd0);
      check("post-rst err", {31'd0, a_err}, 32'd0);

      txn(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, "wr10");
      txn(1'b0, 1'b0, 32'h10, 32'd0, "rd10");
      check("rd10 value", a_rdata, 32'hDEADBEEF);

      txn(1'b0, 1'b1, 32'h12, 32'h12345678, "wr12 misaligned");
      txn(1'b0, 1'b0, 32'h10, 32'd0, "rd10 after bad wr");
      check("rd10 unchanged", a_rdata, 32'hDEADBEEF);

      txn(1'b0, 1'b0, 32'h400, 32'd0, "rd400 out of range");

      for (int i = 0; i < 16; i++) begin
         txn(1'b0, 1'b1, 32'(i) * 32'd4, $urandom, "preload");
      end

      // zero-wait instance: back-to-back reads with req_valid held high
      txn(1'b1, 1'b1, 32'h0, 32'h0BAD_F00D, "b wr0");
      txn(1'b1, 1'b1, 32'h4, 32'h1357_9BDF, "b wr4");
      @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         if (i > 0) @(negedge clk);
         if (b_rvalid === 1'b1) begin
            rsp_q.push_back(i);
            rd_q.push_back(b_rdata);
         end
         drive(1'b1, (acc_q.size() < 2), 1'b0, 32'(acc_q.size()) * 32'd4, 32'd0);
         if (b_valid && b_ready === 1'b1) acc_q.push_back(i);
      end
      drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
      check("b2b accepts", 32'(acc_q.size()), 32'd2);
      check("b2b responses", 32'(rsp_q.size()), 32'd2);
      if (acc_q.size() == 2 && rsp_q.size() == 2) begin
         check("b2b spacing", 32'(acc_q[1] - acc_q[0]), 32'd2);
         check("b2b lat0", 32'(rsp_q[0] - acc_q[0]), 32'd1);
         check("b2b lat1", 32'(rsp_q[1] - acc_q[1]), 32'd1);
         check("b2b rd0", rd_q[0], model[32'd4096]);
         check("b2b rd1", rd_q[1], model[32'd4097]);
      end

      // reset while a write is waiting: no commit, no response
      @(negedge clk);
      drive(1'b0, 1'b1, 1'b1, 32'h20, 32'hA5A5A5A5);
      check("midrst ready", {31'd0, a_ready}, 32'd1);
      @(posedge clk);
      #1;
      drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("midrst ready low", {31'd0, a_ready}, 32'd0);
      check("midrst rvalid 1", {31'd0, a_rvalid}, 32'd0);
      @(negedge clk);
      check("midrst rvalid 2", {31'd0, a_rvalid}, 32'd0);
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("midrst no resp", {31'd0, a_rvalid}, 32'd0);
      end
      txn(1'b0, 1'b0, 32'h20, 32'd0, "rd20 after reset");
      check("rd20 old", a_rdata, model[32'h8]);

      // random traffic: mostly in-range words, some misaligned, some out of range
      for (int k = 0; k < 40; k++) begin
         r = $urandom_range(0, 9);
         if (r == 0) ad = 32'($urandom_range(0, 63)) * 32'd4 + 32'($urandom_range(1, 3));
         else if (r == 1) ad = 32'h400 + 32'($urandom_range(0, 1000)) * 32'd4;
         else ad = 32'($urandom_range(0, 15)) * 32'd4;
         txn(1'b0, 1'($urandom_range(0, 1)), ad, $urandom, "rnd");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the multicycle MIPS datapath's instruction/data memory port.
- Accepts one word read or write request at a time over a valid/ready handshake.
- Inserts a programmable number of wait states, then returns read data and a status pulse.
- Replaces the zero-latency combinational memory so the control FSM can be exercised against realistic memory latency.

Parameters:
- DEPTH, 256, number of 32-bit words; must be a power of two, min 4.
- WAIT_CYCLES, 2, extra cycles between request acceptance and response; range 0..15.
- DATA_W, 32, data width; fixed at 32, and the implementation checks this at elaboration.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous active-high reset
- req_valid  input  1  request present
- req_ready  output  1  responder can accept a request this cycle
- req_we  input  1  1 = write, 0 = read
- req_addr  input  32  byte address; word index = req_addr[31:2]
- req_wdata  input  32  write data
- resp_valid  output  1  single-cycle response pulse
- resp_rdata  output  32  read data, valid while resp_valid
- resp_err  output  1  access error, valid while resp_valid

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (reset), sampled on the rising edge of clk.
- Reset values: state IDLE, req_ready=0 while reset is high, resp_valid=0, resp_rdata=0, resp_err=0, wait counter=0. Memory contents are not cleared by reset.
- States:
  - IDLE: req_ready=1. Acceptance occurs on a cycle where req_valid && req_ready. On acceptance, latch we, addr and wdata; load the counter with WAIT_CYCLES. Go to WAIT if WAIT_CYCLES>0, else go to RESP.
  - WAIT: req_ready=0. Decrement the counter each cycle. When the counter reaches 1, go to RESP on the next edge.
  - RESP: req_ready=0, resp_valid=1 for exactly one cycle. Unconditionally return to IDLE.
- Latency and throughput:
  - Request accepted at edge N produces resp_valid high in cycle N+1+WAIT_CYCLES.
  - Minimum spacing between accepted requests is WAIT_CYCLES+2 cycles.
- Write commit: the array is written on the edge that enters RESP, using the latched data.
- Read data: registered on the edge that enters RESP. resp_rdata holds its value after RESP until the next response.
- Errors: an access errors if addr[1:0]!=0 (misaligned) or addr[31:2] >= DEPTH (out of range). An erroring access suppresses the write, and the response carries resp_rdata=0, resp_err=1.
- No back-pressure on the response: the requester must accept resp_valid in the cycle it is asserted.
- Changes to req_* outside the acceptance cycle are ignored.
- Reset mid-operation: a pending request is dropped. A pending write is not committed and no response is issued.
- Read-after-write: a read accepted after a write's RESP returns the new data.

Optional Feature:
- Macro: MEM_RESP_STATS_EN.
- With the macro defined:
  - Add output ports stat_reads[31:0], stat_writes[31:0], stat_errs[31:0], each reset to 0.
  - Each counter increments on the edge entering RESP, by access type. Errored accesses increment only stat_errs.
  - Counters wrap from 0xFFFFFFFF to 0.
- Without the macro: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package mem_resp_pkg:
  - state enum {IDLE, WAIT, RESP};
  - WORD_LSB=2;
  - constant ADDR_W=32;
  - function is_err(addr, depth).
- One sub-module: mem_array. Single-port synchronous RAM with clk, we, addr[$clog2(DEPTH)-1:0], wdata, rdata; registered read, no reset.
- The FSM, counter and error check live in mem_responder.

Test Plan:
- Reset, then hold idle -> req_ready=1 one cycle after reset deasserts; resp_valid=0, resp_rdata=0.
- Write 0xDEADBEEF to addr 0x10, then read addr 0x10 (WAIT_CYCLES=2) -> read resp_valid exactly 3 cycles after acceptance, resp_rdata=0xDEADBEEF, resp_err=0.
- WAIT_CYCLES=0, back-to-back reads at 0x0 and 0x4 with req_valid held high -> acceptances 2 cycles apart, each response 1 cycle after its acceptance.
- Write 0x12345678 to addr 0x12 (misaligned), then read 0x10 -> first response resp_err=1; read returns the previously stored value, unchanged.
- Read addr 0x400 with DEPTH=256 -> resp_err=1, resp_rdata=0.
- Accept a write of 0xA5A5A5A5 to 0x20, assert reset during WAIT, then read 0x20 -> no response for the write; the read returns the old contents.
